// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared constants for the DMA channel scheduler
package dma_pkg;

  localparam int DMA_NCH     = 4;
  localparam int DMA_CH_W    = $clog2(DMA_NCH);
  localparam int DMA_TIMEOUT = 4096;
  localparam int DMA_TO_W    = 12;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HOLD    = 3'd1;
  localparam logic [2:0] ST_START   = 3'd2;
  localparam logic [2:0] ST_XFER    = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

endpackage

// File: rtl/dma_rr_arbiter.sv
// rtl/dma_rr_arbiter.sv - combinational fixed/round-robin channel picker
module dma_rr_arbiter
  import dma_pkg::*;
#(
  parameter int N = DMA_NCH,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] eligible,
  input  logic [W-1:0] last_grant,
  input  logic         rotate_en,
  output logic [W-1:0] winner,
  output logic         valid
);

  int start;
  int idx;

  // Search begins after the last grant in rotating mode, at channel 0 otherwise.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    start  = rotate_en ? ((int'(last_grant) + 1) % N) : 0;
    for (int i = 0; i < N; i++) begin
      idx = (start + i) % N;
      if (!valid && eligible[idx]) begin
        valid  = 1'b1;
        winner = W'(idx);
      end
    end
  end

endmodule

// File: rtl/dma_channel_sched.sv
// rtl/dma_channel_sched.sv - four-channel DREQ/DACK scheduler with hold handshake,
// watchdog and sticky per-channel abort flags
module dma_channel_sched
  import dma_pkg::*;
#(
  parameter int NCH     = DMA_NCH,
  parameter int TIMEOUT = DMA_TIMEOUT,
  parameter int TO_W    = DMA_TO_W,
  parameter int CW      = $clog2(NCH)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [NCH-1:0] dreq,
  input  logic [NCH-1:0] chan_mask,
  input  logic           rotate_en,
  input  logic           hlda,
  input  logic           xfer_done,
  input  logic [NCH-1:0] err_clr,
  output logic           hrq,
  output logic [NCH-1:0] dack,
  output logic [CW-1:0]  dsel,
  output logic           xfer_start,
  output logic           busy,
  output logic [NCH-1:0] err_flag
);

  logic [2:0]     state, state_nxt;
  logic [CW-1:0]  cur_ch, cur_ch_nxt;
  logic [CW-1:0]  last_grant, last_grant_nxt;
  logic [TO_W-1:0] timer, timer_nxt;
  logic [NCH-1:0] err_set;
  logic [NCH-1:0] eligible;
  logic [NCH-1:0] cur_onehot;
  logic [CW-1:0]  arb_winner;
  logic           arb_valid;
  logic           timer_max;
  logic           cancel;
  logic           active;

  assign eligible   = dreq & ~chan_mask;
  assign cur_onehot = {{(NCH-1){1'b0}}, 1'b1} << cur_ch;
  assign timer_max  = (timer == TO_W'(TIMEOUT - 1));
  assign cancel     = !dreq[cur_ch] || chan_mask[cur_ch];

  dma_rr_arbiter #(
    .N(NCH),
    .W(CW)
  ) u_arb (
    .eligible  (eligible),
    .last_grant(last_grant),
    .rotate_en (rotate_en),
    .winner    (arb_winner),
    .valid     (arb_valid)
  );

  always_comb begin
    state_nxt      = state;
    cur_ch_nxt     = cur_ch;
    last_grant_nxt = last_grant;
    timer_nxt      = timer;
    err_set        = '0;
    case (state)
      ST_IDLE: begin
        if (arb_valid) begin
          cur_ch_nxt = arb_winner;
          state_nxt  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // A withdrawn or masked request abandons the hold without side effects.
        if (cancel) begin
          state_nxt = ST_IDLE;
        end else if (hlda) begin
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        timer_nxt = '0;
        state_nxt = ST_XFER;
      end
      ST_XFER: begin
        // Completion is checked first so a done on the final watchdog cycle is clean.
        if (xfer_done) begin
          state_nxt = ST_RELEASE;
        end else if (!hlda || timer_max) begin
          err_set   = cur_onehot;
          state_nxt = ST_RELEASE;
        end else begin
          timer_nxt = timer + TO_W'(1);
        end
      end
      ST_RELEASE: begin
        last_grant_nxt = cur_ch;
        if (!hlda) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cur_ch     <= '0;
      last_grant <= CW'(NCH - 1);
      timer      <= '0;
      err_flag   <= '0;
    end else begin
      state      <= state_nxt;
      cur_ch     <= cur_ch_nxt;
      last_grant <= last_grant_nxt;
      timer      <= timer_nxt;
      err_flag   <= (err_flag & ~err_clr) | err_set;
    end
  end

  // Outputs decode straight from registered state so reset clears them at once.
  assign active     = (state == ST_START) || (state == ST_XFER);
  assign hrq        = (state == ST_HOLD) || active;
  assign dack       = active ? cur_onehot : '0;
  assign dsel       = active ? cur_ch : '0;
  assign xfer_start = (state == ST_START);
  assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_dma_channel_sched.sv
// tb/tb_dma_channel_sched.sv - self-checking bench for dma_channel_sched
module tb_dma_channel_sched;

  localparam int NCH     = 4;
  localparam int TIMEOUT = 8;
  localparam int TO_W    = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] dreq = '0, chan_mask = '0, err_clr = '0;
  logic       rotate_en = 1'b0, hlda = 1'b0, xfer_done = 1'b0;
  logic       hrq, xfer_start, busy;
  logic [3:0] dack, err_flag;
  logic [1:0] dsel;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  dma_channel_sched #(
    .NCH(NCH),
    .TIMEOUT(TIMEOUT),
    .TO_W(TO_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .dreq      (dreq),
    .chan_mask (chan_mask),
    .rotate_en (rotate_en),
    .hlda      (hlda),
    .xfer_done (xfer_done),
    .err_clr   (err_clr),
    .hrq       (hrq),
    .dack      (dack),
    .dsel      (dsel),
    .xfer_start(xfer_start),
    .busy      (busy),
    .err_flag  (err_flag)
  );

  typedef struct {
    logic [3:0] dreq;
    logic       hlda;
    logic       done;
    logic       e_hrq;
    logic [3:0] e_dack;
    logic [1:0] e_dsel;
    logic       e_start;
    logic       e_busy;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    dreq = '0; chan_mask = '0; err_clr = '0;
    rotate_en = 1'b0; hlda = 1'b0; xfer_done = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic wait_hrq(input string name);
    int n;
    n = 0;
    while (!hrq && n < 20) begin
      tick();
      n++;
    end
    check({name, " hrq"}, 32'(hrq), 32'd1);
  endtask

  // mode 0: master completes after k XFER cycles; 1: bus lost after k cycles; 2: watchdog
  task automatic run_xfer(input string name, input int exp_ch, input int mode, input int k,
                          input int hold_dly, input logic [3:0] clr_with_loss,
                          input logic [3:0] exp_err);
    int cnt;
    wait_hrq(name);
    repeat (hold_dly) tick();
    hlda = 1'b1;
    tick();
    check({name, " start"}, {25'd0, xfer_start, dsel, dack},
          {25'd0, 1'b1, 2'(exp_ch), 4'(1 << exp_ch)});
    if (mode == 0) begin
      repeat (k) tick();
      xfer_done = 1'b1;
      tick();
      xfer_done = 1'b0;
      check({name, " done drop"}, {27'd0, hrq, dack}, 32'd0);
      tick();
      check({name, " release wait"}, {30'd0, busy, hrq}, 32'd2);
      hlda = 1'b0;
      tick();
    end else if (mode == 1) begin
      repeat (k) tick();
      hlda = 1'b0;
      err_clr = clr_with_loss;
      tick();
      err_clr = '0;
      check({name, " loss drop"}, {27'd0, hrq, dack}, 32'd0);
      tick();
    end else begin
      cnt = 0;
      for (int i = 0; i < 20 && dack != 0; i++) begin
        tick();
        if (dack != 0) cnt++;
      end
      check({name, " xfer cycles"}, 32'(cnt), 32'(TIMEOUT));
      hlda = 1'b0;
      tick();
    end
    check({name, " idle"}, 32'(busy), 32'd0);
    check({name, " err"}, 32'(err_flag), 32'(exp_err));
  endtask

  // Reference pick: rotate the eligible vector to the search origin, take the lowest bit.
  function automatic int pick(input logic [3:0] elig, input int last, input logic rot);
    int s;
    logic [7:0] dbl;
    logic [3:0] r;
    s   = rot ? (last + 1) % 4 : 0;
    dbl = {elig, elig};
    r   = 4'(dbl >> s);
    for (int j = 0; j < 4; j++) if (r[j]) return (s + j) % 4;
    return -1;
  endfunction

  initial begin
    int rr_seq[5];
    int mk_seq[4];
    int ref_last, w, mode, k;
    logic [3:0] ref_err, elig, clr;

    tbl[0] = '{4'b0010, 1'b0, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b1};
    tbl[1] = '{4'b0010, 1'b0, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b1};
    tbl[2] = '{4'b0010, 1'b0, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b1};
    tbl[3] = '{4'b0010, 1'b1, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1};
    tbl[4] = '{4'b0010, 1'b1, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b0, 1'b1};
    tbl[5] = '{4'b0010, 1'b1, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b0, 1'b1};
    tbl[6] = '{4'b0010, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1};
    tbl[7] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[8] = '{4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
    rr_seq = '{0, 1, 2, 3, 0};
    mk_seq = '{0, 1, 3, 0};

    tick();
    check("reset outputs", {19'd0, hrq, dack, dsel, xfer_start, busy, err_flag}, 32'd0);
    do_reset();
    check("post reset idle", {19'd0, hrq, dack, dsel, xfer_start, busy, err_flag}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      dreq = tbl[i].dreq;
      hlda = tbl[i].hlda;
      xfer_done = tbl[i].done;
      tick();
      check($sformatf("vec%0d", i), {23'd0, hrq, dack, dsel, xfer_start, busy},
            {23'd0, tbl[i].e_hrq, tbl[i].e_dack, tbl[i].e_dsel, tbl[i].e_start, tbl[i].e_busy});
    end
    xfer_done = 1'b0;

    do_reset();
    dreq = 4'b1110;
    for (int i = 0; i < 3; i++) run_xfer($sformatf("fixed%0d", i), 1, 0, 2, 1, 4'd0, 4'd0);

    do_reset();
    rotate_en = 1'b1;
    dreq = 4'b1111;
    for (int i = 0; i < 5; i++) run_xfer($sformatf("rr%0d", i), rr_seq[i], 0, 1, 0, 4'd0, 4'd0);

    do_reset();
    rotate_en = 1'b1;
    chan_mask = 4'b0100;
    dreq = 4'b1111;
    for (int i = 0; i < 4; i++) run_xfer($sformatf("mask%0d", i), mk_seq[i], 0, 3, 2, 4'd0, 4'd0);

    do_reset();
    dreq = 4'b0100;
    run_xfer("timeout", 2, 2, 0, 0, 4'd0, 4'b0100);
    dreq = 4'b0000;
    err_clr = 4'b0100;
    tick();
    err_clr = 4'b0000;
    check("err_clr", 32'(err_flag), 32'd0);

    // last_grant is 2 now; a cancelled hold must leave it there
    dreq = 4'b0001;
    wait_hrq("cancel");
    tick();
    dreq = 4'b0000;
    tick();
    check("cancel drop", {26'd0, hrq, dack, busy}, 32'd0);
    rotate_en = 1'b1;
    dreq = 4'b1111;
    run_xfer("after cancel", 3, 0, 1, 0, 4'd0, 4'd0);

    do_reset();
    dreq = 4'b0001;
    run_xfer("busloss", 0, 1, 3, 0, 4'b0001, 4'b0001);
    dreq = 4'b0000;
    err_clr = 4'b0001;
    tick();
    err_clr = 4'b0000;
    check("busloss clr", 32'(err_flag), 32'd0);

    do_reset();
    dreq = 4'b1000;
    wait_hrq("areset");
    hlda = 1'b1;
    tick();
    tick();
    check("areset in xfer", {28'd0, dack}, 32'h8);
    #2;
    reset = 1'b0;
    #1;
    check("areset outputs", {19'd0, hrq, dack, dsel, xfer_start, busy, err_flag}, 32'd0);
    hlda = 1'b0;
    dreq = 4'b0000;
    tick();
    reset = 1'b1;

    do_reset();
    ref_last = 3;
    ref_err = '0;
    for (int t = 0; t < 60; t++) begin
      rotate_en = 1'($urandom_range(0, 1));
      chan_mask = 4'($urandom);
      dreq      = 4'($urandom);
      clr       = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      err_clr   = clr;
      ref_err   = ref_err & ~clr;
      elig      = dreq & ~chan_mask;
      tick();
      err_clr = '0;
      if (elig == 0) begin
        check($sformatf("rnd%0d quiet", t), {30'd0, hrq, busy}, 32'd0);
        check($sformatf("rnd%0d err", t), 32'(err_flag), 32'(ref_err));
        continue;
      end
      w = pick(elig, ref_last, rotate_en);
      check($sformatf("rnd%0d hold", t), {30'd0, hrq, busy}, 32'd3);
      // arbitration inputs on other channels are free to move once a winner is held
      chan_mask = 4'($urandom) & ~4'(1 << w);
      rotate_en = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 9);
      k = $urandom_range(1, 7);
      if (mode == 9) begin
        tick();
        if ($urandom_range(0, 1) == 1) dreq[w] = 1'b0;
        else chan_mask[w] = 1'b1;
        tick();
        check($sformatf("rnd%0d cancel", t), {26'd0, hrq, dack, busy}, 32'd0);
      end else if (mode <= 5) begin
        run_xfer($sformatf("rnd%0d done", t), w, 0, k, $urandom_range(0, 3), 4'd0, ref_err);
        ref_last = w;
      end else if (mode <= 7) begin
        ref_err[w] = 1'b1;
        run_xfer($sformatf("rnd%0d loss", t), w, 1, k, $urandom_range(0, 3), 4'd0, ref_err);
        ref_last = w;
      end else begin
        ref_err[w] = 1'b1;
        run_xfer($sformatf("rnd%0d wdog", t), w, 2, 0, $urandom_range(0, 3), 4'd0, ref_err);
        ref_last = w;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
